// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - keypad-loaded MM:SS cook timer with BCD countdown and alarm
module cook_timer #(
  parameter int ALARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] D,
  input  logic       load,
  input  logic       pgt_1hz,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       kp_enable,
  output logic       running,
  output logic       alarm
);

  localparam int CW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   digits, digits_nxt, digits_dec;
  logic [CW-1:0] alarm_cnt, alarm_cnt_nxt, alarm_cnt_inc;
  logic          alarm_nxt, kp_enable_nxt, running_nxt;
  logic          load_q, start_q, stop_q, pgt_q;
  logic          load_re, start_re, stop_re, pgt_re;
  logic          digit_ok, time_zero;

  // Borrow ripples seconds -> tens -> minutes; minutes only borrow when nonzero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else if (t[15:12] != 4'd0) begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign load_re       = load & ~load_q;
  assign start_re      = start & ~start_q;
  assign stop_re       = stop & ~stop_q;
  assign pgt_re        = pgt_1hz & ~pgt_q;
  assign digit_ok      = (D <= 4'd9);
  assign time_zero     = (digits == 16'h0000);
  assign digits_dec    = bcd_dec(digits);
  assign alarm_cnt_inc = alarm_cnt + 1'b1;

  assign min_tens = digits[15:12];
  assign min_ones = digits[11:8];
  assign sec_tens = digits[7:4];
  assign sec_ones = digits[3:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      load_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      pgt_q   <= 1'b0;
    end else begin
      load_q  <= load;
      start_q <= start;
      stop_q  <= stop;
      pgt_q   <= pgt_1hz;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      digits    <= 16'h0000;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
      kp_enable <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      digits    <= digits_nxt;
      alarm     <= alarm_nxt;
      alarm_cnt <= alarm_cnt_nxt;
      kp_enable <= kp_enable_nxt;
      running   <= running_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    digits_nxt    = digits;
    alarm_nxt     = alarm;
    alarm_cnt_nxt = alarm_cnt;
    case (state)
      IDLE: begin
        if (!stop_re && !start_re && load_re && digit_ok) begin
          digits_nxt = {digits[11:0], D};
          state_nxt  = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_re) begin
          digits_nxt = 16'h0000;
          state_nxt  = IDLE;
        end else if (start_re) begin
          if (!time_zero) state_nxt = RUN;
        end else if (load_re && digit_ok) begin
          digits_nxt = {digits[11:0], D};
        end
      end
      RUN: begin
        if (stop_re) begin
          state_nxt = PAUSE;
        end else if (pgt_re) begin
          digits_nxt = digits_dec;
          if (digits_dec == 16'h0000) begin
            state_nxt     = DONE;
            alarm_nxt     = 1'b1;
            alarm_cnt_nxt = '0;
          end
        end
      end
      PAUSE: begin
        if (stop_re) begin
          digits_nxt = 16'h0000;
          state_nxt  = IDLE;
        end else if (start_re) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (stop_re) begin
          state_nxt     = IDLE;
          alarm_nxt     = 1'b0;
          alarm_cnt_nxt = '0;
        end else if (!start_re && load_re && digit_ok) begin
          digits_nxt    = {12'h000, D};
          state_nxt     = ENTRY;
          alarm_nxt     = 1'b0;
          alarm_cnt_nxt = '0;
        end else if (pgt_re && alarm) begin
          alarm_cnt_nxt = alarm_cnt_inc;
          if (alarm_cnt_inc == CW'(ALARM_TICKS)) alarm_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        digits_nxt = 16'h0000;
        alarm_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    kp_enable_nxt = (state_nxt == IDLE) || (state_nxt == ENTRY) || (state_nxt == DONE);
    running_nxt   = (state_nxt == RUN);
  end

endmodule
